// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with a busy scoreboard for the pipelined core. It sits
// between decode and execute, and writeback drives the write port.
//
// - Two combinational read ports. When BYPASS != 0, the write data is forwarded
//   to a read port in the same cycle.
// - One synchronous write port. Writeback is always accepted.
// - Operand-B select: register rd2 or the immediate.
// - One busy bit per register. It tracks long-latency writebacks so decode can
//   stall on RAW hazards.
// - Register 0 reads as zero. It is never written and never busy.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   ra1, ra2  in   AW      read addresses
//   rd1, rd2  out  XLEN    read data (combinational)
//   use1/2    in   1       decode really consumes ra1 / ra2
//   imm       in   XLEN    sign-extended immediate
//   opb_sel   in   2       2'b01 -> srcb = rd2, any other value -> srcb = imm
//   srcb      out  XLEN    ALU operand B
//   we,wa,wd  in           writeback enable / address / data
//   iss_en    in   1       long-latency op issued, marks iss_rd busy
//   iss_rd    in   AW      destination of the issued op
//   hz1, hz2  out  1       RAW hazard on port 1 / port 2
//   stall     out  1       hz1 | hz2
//   pend_cnt  out  AW+1    number of busy registers (registered)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            use1,
    input  logic            use2,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      opb_sel,
    output logic [XLEN-1:0] srcb,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            hz1,
    output logic            hz2,
    output logic            stall,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     pend_cnt_q;
    logic [AW:0]     pend_cnt_d;

    logic bypass_on;
    logic wr_ok;
    logic iss_ok;
    logic fwd1;
    logic fwd2;
    logic busy_rise;
    logic busy_fall;

    assign bypass_on = (BYPASS != 0);
    assign wr_ok     = we && (wa != '0);
    assign iss_ok    = iss_en && (iss_rd != '0);

    // Forwarding a write to x0 is never needed because x0 reads as zero.
    assign fwd1 = bypass_on && wr_ok && (wa == ra1);
    assign fwd2 = bypass_on && wr_ok && (wa == ra2);

    // ---------------------------------------------------------------- read
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = fwd1 ? wd : mem_q[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = fwd2 ? wd : mem_q[ra2];
        end
    end

    assign srcb = (opb_sel == 2'b01) ? rd2 : imm;

    // -------------------------------------------------------------- hazard
    // A writeback that matches the read address clears the hazard in the same
    // cycle, but only when its data is forwarded. Without forwarding, the
    // reader must wait one more cycle for the array to update.
    assign hz1   = use1 && (ra1 != '0) && busy_q[ra1] && !fwd1;
    assign hz2   = use2 && (ra2 != '0) && busy_q[ra2] && !fwd2;
    assign stall = hz1 | hz2;

    // --------------------------------------------------- next-state update
    // The issue is applied after the write. When both hit the same register,
    // the new issue wins and the register stays busy.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[wa]  = wd;
            busy_d[wa] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_rd] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    // At most one busy bit can rise (issue) and one can fall (writeback) per
    // edge. The counter therefore tracks popcount(busy) with a +1/-1 step.
    // busy[0] never rises, so the count stays within 0..NREG-1 and cannot wrap.
    assign busy_rise = iss_ok && !busy_q[iss_rd];
    assign busy_fall = wr_ok && busy_q[wa] && !(iss_ok && (iss_rd == wa));

    always_comb begin
        pend_cnt_d = pend_cnt_q
                   + {{AW{1'b0}}, busy_rise}
                   - {{AW{1'b0}}, busy_fall};
    end

    assign pend_cnt = pend_cnt_q;

    // ------------------------------------------------------------- flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

endmodule
